// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, next-PC select encodings and fetch FSM states.
package cpu_pkg;

    // Opcodes as presented on Instruction_ctrlIn (ir[31:26])
    localparam logic [5:0] OP_NOOP = 6'b000000;
    localparam logic [5:0] OP_JUMP = 6'b000001;
    localparam logic [5:0] OP_MOV  = 6'b010000;
    localparam logic [5:0] OP_BEQ  = 6'b100000;
    localparam logic [5:0] OP_BNE  = 6'b100001;
    localparam logic [5:0] OP_SWI  = 6'b111100;

    // Next-PC source select driven by the Controller
    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'd0,
        PCSRC_ALUOUT = 2'd1,
        PCSRC_JUMP   = 2'd2,
        PCSRC_HOLD   = 2'd3
    } pcSrcT;

    // Fetch handshake states
    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_WAIT = 1'b1
    } fetchStateT;

endpackage

// File: rtl/instr_fetch_unit_next_pc_mux.sv
// Next-PC selection: ALU result, ALUOut, jump target or hold current PC.
module next_pc_mux
    import cpu_pkg::*;
(
    input  pcSrcT       pcSrc,
    input  logic [31:0] pc,
    input  logic [25:0] jumpIndex,
    input  logic [31:0] aluResult,
    input  logic [31:0] aluOut,
    output logic [31:0] nextPc
);

    // Select the candidate PC; the jump target keeps the current PC region bits
    always_comb begin
        nextPc = pc;
        unique case (pcSrc)
            PCSRC_ALU:    nextPc = aluResult;
            PCSRC_ALUOUT: nextPc = aluOut;
            PCSRC_JUMP:   nextPc = {pc[31:28], jumpIndex, 2'b00};
            PCSRC_HOLD:   nextPc = pc;
            default:      nextPc = pc;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC and IR registers driven by Controller strobes,
// with a single-outstanding memory handshake that stalls slow fetches.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky misalign_err output.
module instr_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PCWrite_ctrl,
    input  logic        PCWriteCond_ctrl,
    input  logic        BEQ_ctrl,
    input  logic [1:0]  PCSrc_ctrl,
    input  logic        IRWrite_ctrl,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic [5:0]  Instruction_ctrlIn,
    output logic        fetch_stall,
    output logic        mem_req
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);
    import cpu_pkg::*;

    fetchStateT  state;
    logic [31:0] pcReg;
    logic [31:0] irReg;
    logic [31:0] nextPc;
    logic [31:0] pendPc;
    logic        pendLoad;
    logic        branchTaken;
    logic        loadEn;

    assign branchTaken = PCWriteCond_ctrl & (BEQ_ctrl ? alu_zero : ~alu_zero);
    assign loadEn      = PCWrite_ctrl | branchTaken;

    next_pc_mux uNextPcMux (
        .pcSrc     (pcSrcT'(PCSrc_ctrl)),
        .pc        (pcReg),
        .jumpIndex (irReg[25:0]),
        .aluResult (alu_result),
        .aluOut    (alu_out),
        .nextPc    (nextPc)
    );

    // Fetch FSM with PC/IR updates; a stalled fetch parks its PC load until data arrives
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= FETCH_IDLE;
            pcReg    <= PC_RESET;
            irReg    <= '0;
            pendPc   <= '0;
            pendLoad <= 1'b0;
        end else begin
            unique case (state)
                FETCH_IDLE: begin
                    if (IRWrite_ctrl && !mem_ready) begin
                        state    <= FETCH_WAIT;
                        pendLoad <= loadEn;
                        pendPc   <= nextPc;
                    end else begin
                        if (IRWrite_ctrl) irReg <= mem_rdata;
                        if (loadEn)       pcReg <= nextPc;
                    end
                end
                FETCH_WAIT: begin
                    if (mem_ready) begin
                        irReg    <= mem_rdata;
                        if (pendLoad) pcReg <= pendPc;
                        pendLoad <= 1'b0;
                        state    <= FETCH_IDLE;
                    end
                end
                default: state <= FETCH_IDLE;
            endcase
        end
    end

    assign pc                 = pcReg;
    assign ir                 = irReg;
    assign Instruction_ctrlIn = irReg[31:26];
    assign fetch_stall        = (state == FETCH_WAIT);
    assign mem_req            = (state == FETCH_WAIT) | IRWrite_ctrl;

`ifdef FETCH_ALIGN_CHECK_EN
    logic        commitEn;
    logic [31:0] commitVal;
    logic        misalignReg;

    // Identify the value a PC load commits on this edge, immediate or deferred
    always_comb begin
        commitEn  = 1'b0;
        commitVal = nextPc;
        if (state == FETCH_IDLE) begin
            commitEn  = loadEn & ~(IRWrite_ctrl & ~mem_ready);
            commitVal = nextPc;
        end else begin
            commitEn  = mem_ready & pendLoad;
            commitVal = pendPc;
        end
    end

    // Sticky misalignment flag, cleared only by reset
    always_ff @(posedge clock) begin
        if (!reset)
            misalignReg <= 1'b0;
        else if (commitEn && (commitVal[1:0] != 2'b00))
            misalignReg <= 1'b1;
    end

    assign misalign_err = misalignReg;
`endif

endmodule
